seq_magnitude_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands.
- Scans MSB-first, DIGIT bits per cycle, and supports signed or unsigned comparison.
- Supports cascade inputs (g/e/l) for chaining wider comparisons, and optional early exit on the first differing digit.
- Runs under a start/busy/done handshake, so wide compares fit datapaths where a single-cycle WIDTH-bit compare would miss timing.

---
 rtl/seq_magnitude_comparator.sv | 167 ++++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, signed/unsigned, with g/e/l cascade.
// Latency: start edge to done = digits scanned (EARLY_EXIT=1) or WIDTH/DIGIT cycles (EARLY_EXIT=0).
// Backpressure: none; start is ignored while busy, and operands are latched on the accepted start.
//
// Ports:
//   clk, rst_n                 - clock and synchronous active-low reset
//   start                      - request, accepted only when busy=0
//   a, b, signed_mode          - operands and compare mode, latched on accept
//   g_in, e_in, l_in           - cascade result from a more-significant stage, latched on accept
//   busy                       - comparison in progress
//   done                       - one-cycle pulse when g_out/e_out/l_out update
//   g_out, e_out, l_out        - registered one-hot result (A>B, A==B, A<B)
module seq_magnitude_comparator #(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             g_in,
    input  logic             e_in,
    input  logic             l_in,
    output logic             busy,
    output logic             done,
    output logic             g_out,
    output logic             e_out,
    output logic             l_out
);

    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               sm_q, g_q, e_q, l_q;
    // First unequal digit seen so far (only used when scanning all digits).
    logic               hit_q, hit_nxt;
    logic               hit_g_q, hit_g_nxt;

    logic [DIGIT-1:0]   dig_a, dig_b;
    logic               dig_gt, dig_ne;
    logic               capture, fin;
    logic               res_g, res_e, res_l;

    // Two's-complement order equals unsigned order once the sign bits are
    // flipped, so only the top digit needs adjusting in signed mode.
    always_comb begin
        dig_a = a_q[idx*DIGIT +: DIGIT];
        dig_b = b_q[idx*DIGIT +: DIGIT];
        if (sm_q && (idx == TOP_IDX)) begin
            dig_a[DIGIT-1] = ~dig_a[DIGIT-1];
            dig_b[DIGIT-1] = ~dig_b[DIGIT-1];
        end
        dig_gt = (dig_a > dig_b);
        dig_ne = (dig_a != dig_b);
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        hit_nxt   = hit_q;
        hit_g_nxt = hit_g_q;
        capture   = 1'b0;
        fin       = 1'b0;
        res_g     = 1'b0;
        res_e     = 1'b0;
        res_l     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    idx_nxt   = TOP_IDX;
                    hit_nxt   = 1'b0;
                    hit_g_nxt = 1'b0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (dig_ne && !hit_q) begin
                    hit_nxt   = 1'b1;
                    hit_g_nxt = dig_gt;
                end
                if ((EARLY_EXIT != 0) && dig_ne) begin
                    fin   = 1'b1;
                    res_g = dig_gt;
                    res_l = ~dig_gt;
                end else if (idx == '0) begin
                    fin = 1'b1;
                    if (hit_q) begin
                        res_g = hit_g_q;
                        res_l = ~hit_g_q;
                    end else if (dig_ne) begin
                        res_g = dig_gt;
                        res_l = ~dig_gt;
                    end else if (g_q) begin
                        res_g = 1'b1;
                    end else if (l_q) begin
                        res_l = 1'b1;
                    end else begin
                        // e_in set, or no cascade input at all: operands are equal.
                        res_e = 1'b1;
                    end
                end else begin
                    idx_nxt = idx - 1'b1;
                end
                if (fin) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            hit_q   <= 1'b0;
            hit_g_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
            l_q     <= 1'b0;
            done    <= 1'b0;
            g_out   <= 1'b0;
            e_out   <= 1'b0;
            l_out   <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            hit_q   <= hit_nxt;
            hit_g_q <= hit_g_nxt;
            done    <= fin;
            if (capture) begin
                a_q  <= a;
                b_q  <= b;
                sm_q <= signed_mode;
                g_q  <= g_in;
                e_q  <= e_in;
                l_q  <= l_in;
            end
            if (fin) begin
                g_out <= res_g;
                e_out <= res_e;
                l_out <= res_l;
            end
        end
    end

    assign busy = (state == RUN);

    // e_q is latched for completeness; equality is also the no-cascade default.
    logic unused_e;
    assign unused_e = e_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed testbench: one early-exit and one fixed-latency comparator, WIDTH=16, DIGIT=4.
// Latency: measured in rising edges from the accepted start edge to the done-high cycle.
// Backpressure: exercises start during RUN, reset mid-RUN and back-to-back starts.
module tb_seq_magnitude_comparator;

    logic        clk;
    logic        rst_n;
    logic        start_ee, start_fx;
    logic [15:0] a, b;
    logic        sm, gi, ei, li;
    logic        busy_ee, done_ee, g_ee, e_ee, l_ee;
    logic        busy_fx, done_fx, g_fx, e_fx, l_fx;

    int checks = 0;
    int errors = 0;
    int lat;
    int ndone;

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .rst_n(rst_n), .start(start_ee), .a(a), .b(b), .signed_mode(sm),
        .g_in(gi), .e_in(ei), .l_in(li), .busy(busy_ee), .done(done_ee),
        .g_out(g_ee), .e_out(e_ee), .l_out(l_ee)
    );

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) u_fx (
        .clk(clk), .rst_n(rst_n), .start(start_fx), .a(a), .b(b), .signed_mode(sm),
        .g_in(gi), .e_in(ei), .l_in(li), .busy(busy_fx), .done(done_fx),
        .g_out(g_fx), .e_out(e_fx), .l_out(l_fx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one compare and return the start-to-done latency (0 if done never came).
    // With chg set, b is overwritten with bmid after the first RUN cycle.
    task automatic do_cmp(input bit fx, input logic [15:0] av, input logic [15:0] bv,
                          input logic smv, input logic gv, input logic ev, input logic lv,
                          input bit chg, input logic [15:0] bmid, output int l);
        @(negedge clk);
        a = av; b = bv; sm = smv; gi = gv; ei = ev; li = lv;
        if (fx) start_fx = 1'b1; else start_ee = 1'b1;
        @(posedge clk); #1;
        start_ee = 1'b0; start_fx = 1'b0;
        l = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (chg && c == 1) b = bmid;
            if (fx ? done_fx : done_ee) begin
                l = c;
                break;
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; start_ee = 1'b0; start_fx = 1'b0;
        a = '0; b = '0; sm = 1'b0; gi = 1'b0; ei = 1'b0; li = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, busy_ee}, 32'd0);
        chk("reset_done", {31'b0, done_ee}, 32'd0);
        chk("reset_gel",  {29'b0, g_ee, e_ee, l_ee}, 32'b000);
        @(negedge clk) rst_n = 1'b1;

        // Equal operands, e_in set: full scan.
        do_cmp(0, 16'h1234, 16'h1234, 0, 0, 1, 0, 0, 16'h0, lat);
        chk("eq_lat", lat, 4);
        chk("eq_gel", {29'b0, g_ee, e_ee, l_ee}, 32'b010);
        chk("eq_busy_at_done", {31'b0, busy_ee}, 32'd0);

        // Top digit differs: unsigned vs signed.
        do_cmp(0, 16'h8000, 16'h7FFF, 0, 0, 1, 0, 0, 16'h0, lat);
        chk("top_uns_lat", lat, 1);
        chk("top_uns_gel", {29'b0, g_ee, e_ee, l_ee}, 32'b100);
        do_cmp(0, 16'h8000, 16'h7FFF, 1, 0, 1, 0, 0, 16'h0, lat);
        chk("top_sgn_lat", lat, 1);
        chk("top_sgn_gel", {29'b0, g_ee, e_ee, l_ee}, 32'b001);

        // Differences in the last and third digit.
        do_cmp(0, 16'h1235, 16'h1234, 0, 0, 1, 0, 0, 16'h0, lat);
        chk("low_lat", lat, 4);
        chk("low_gel", {29'b0, g_ee, e_ee, l_ee}, 32'b100);
        chk("b2b_done_high", {31'b0, done_ee}, 32'd1);
        // Back-to-back: issued in the cycle done is high.
        do_cmp(0, 16'h1224, 16'h1234, 0, 0, 1, 0, 0, 16'h0, lat);
        chk("mid_lat", lat, 3);
        chk("mid_gel", {29'b0, g_ee, e_ee, l_ee}, 32'b001);

        // Signed negative vs negative: -1 (FFFF) > -2 (FFFE).
        do_cmp(0, 16'hFFFF, 16'hFFFE, 1, 0, 1, 0, 0, 16'h0, lat);
        chk("neg_lat", lat, 4);
        chk("neg_gel", {29'b0, g_ee, e_ee, l_ee}, 32'b100);

        // Cascade priority on equal operands.
        do_cmp(0, 16'hABCD, 16'hABCD, 0, 1, 1, 0, 0, 16'h0, lat);
        chk("casc_g_gel", {29'b0, g_ee, e_ee, l_ee}, 32'b100);
        do_cmp(0, 16'hABCD, 16'hABCD, 0, 0, 1, 1, 0, 16'h0, lat);
        chk("casc_l_gel", {29'b0, g_ee, e_ee, l_ee}, 32'b001);
        do_cmp(0, 16'hABCD, 16'hABCD, 0, 0, 0, 0, 0, 16'h0, lat);
        chk("casc_none_gel", {29'b0, g_ee, e_ee, l_ee}, 32'b010);

        // Fixed-latency instance.
        do_cmp(1, 16'h8000, 16'h7FFF, 0, 0, 1, 0, 0, 16'h0, lat);
        chk("fx_lat", lat, 4);
        chk("fx_gel", {29'b0, g_fx, e_fx, l_fx}, 32'b100);
        do_cmp(1, 16'h8000, 16'h7FFF, 0, 0, 1, 0, 1, 16'h0000, lat);
        chk("fx_chg_lat", lat, 4);
        chk("fx_chg_gel", {29'b0, g_fx, e_fx, l_fx}, 32'b100);
        do_cmp(1, 16'h1234, 16'h1234, 0, 0, 1, 0, 1, 16'hFFFF, lat);
        chk("fx_chg_eq_gel", {29'b0, g_fx, e_fx, l_fx}, 32'b010);
        do_cmp(1, 16'h8000, 16'h7FFF, 1, 0, 1, 0, 0, 16'h0, lat);
        chk("fx_sgn_lat", lat, 4);
        chk("fx_sgn_gel", {29'b0, g_fx, e_fx, l_fx}, 32'b001);

        // start pulsed during RUN is ignored; operand change has no effect.
        @(negedge clk);
        a = 16'h1234; b = 16'h1234; sm = 0; gi = 0; ei = 1; li = 0; start_ee = 1'b1;
        @(posedge clk); #1 start_ee = 1'b0;
        @(posedge clk); #1;
        chk("run_busy", {31'b0, busy_ee}, 32'd1);
        @(negedge clk);
        a = 16'h8000; b = 16'h7FFF; start_ee = 1'b1;
        @(posedge clk); #1 start_ee = 1'b0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done_ee) ndone++;
        end
        chk("restart_ndone", ndone, 1);
        chk("restart_gel", {29'b0, g_ee, e_ee, l_ee}, 32'b010);

        // Reset in the middle of a 4-cycle compare.
        @(negedge clk);
        a = 16'h1234; b = 16'h1234; start_ee = 1'b1;
        @(posedge clk); #1 start_ee = 1'b0;
        @(posedge clk); #1;
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", {31'b0, busy_ee}, 32'd0);
        chk("rst_done", {31'b0, done_ee}, 32'd0);
        chk("rst_gel", {29'b0, g_ee, e_ee, l_ee}, 32'b000);
        @(negedge clk) rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done_ee) ndone++;
        end
        chk("rst_no_done", ndone, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
